// File: rtl/alu_muldiv_seq.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU sequencer that borrows the shared EX-stage
// ALU adder/subtractor one iteration per granted cycle and owns the HI/LO registers.
module alu_muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_fun,
    output logic        alu_sign,
    input  logic [31:0] alu_z
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        is_div_q, is_div_d;
    logic        neg_q_q, neg_q_d;
    logic        neg_r_q, neg_r_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] whi_q, whi_d;
    logic [31:0] wlo_q, wlo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        accept_s;
    logic        carry_s;
    logic [63:0] prod_s;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        logic [31:0] r;
        if (sgn && v[31]) begin
            r = (~v) + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
    assign done     = (state_q == S_DONE);
    assign alu_sign = 1'b0;

    // ALU operand drive: only ITER borrows the ALU, everything else is parked at zero
    always_comb begin
        alu_req = 1'b0;
        alu_a   = 32'd0;
        alu_b   = 32'd0;
        alu_fun = 6'b000000;
        if (state_q == S_ITER) begin
            alu_req = 1'b1;
            if (is_div_q) begin
                alu_a   = {whi_q[30:0], wlo_q[31]};
                alu_b   = opb_q;
                alu_fun = 6'b000001;
            end else begin
                alu_a   = whi_q;
                alu_b   = wlo_q[0] ? opa_q : 32'd0;
                alu_fun = 6'b000000;
            end
        end else begin
            alu_req = 1'b0;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        whi_d    = whi_q;
        wlo_d    = wlo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
        carry_s  = 1'b0;
        prod_s   = 64'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_PREP;
                    is_div_d = op[1];
                    opa_d    = abs32(rs_val, op[0]);
                    opb_d    = abs32(rt_val, op[0]);
                    neg_q_d  = op[0] & (rs_val[31] ^ rt_val[31]);
                    neg_r_d  = op[0] & rs_val[31];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                cnt_d = 5'd0;
                whi_d = 32'd0;
                if (is_div_q) begin
                    if (opb_q == 32'd0) begin
                        // |rs| re-signed by neg_r in FIX restores the raw dividend into HI
                        whi_d   = opa_q;
                        wlo_d   = 32'hFFFF_FFFF;
                        neg_q_d = 1'b0;
                        state_d = S_FIX;
                    end else begin
                        wlo_d   = opa_q;
                        state_d = S_ITER;
                    end
                end else begin
                    wlo_d   = opb_q;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (alu_gnt) begin
                    if (is_div_q) begin
                        accept_s = whi_q[31] | (alu_a >= opb_q);
                        whi_d    = accept_s ? alu_z : alu_a;
                        wlo_d    = {wlo_q[30:0], accept_s};
                    end else begin
                        carry_s = (alu_z < alu_a);
                        whi_d   = {carry_s, alu_z[31:1]};
                        wlo_d   = {alu_z[0], wlo_q[31:1]};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_ITER;
                    end
                end else begin
                    state_d = S_ITER;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = neg_r_q ? ((~whi_q) + 32'd1) : whi_q;
                    lo_d = neg_q_q ? ((~wlo_q) + 32'd1) : wlo_q;
                end else begin
                    prod_s = neg_q_q ? ((~{whi_q, wlo_q}) + 64'd1) : {whi_q, wlo_q};
                    hi_d   = prod_s[63:32];
                    lo_d   = prod_s[31:0];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with asynchronous abort
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            opa_q    <= 32'd0;
            opb_q    <= 32'd0;
            whi_q    <= 32'd0;
            wlo_q    <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            cnt_q    <= 5'd0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            whi_q    <= whi_d;
            wlo_q    <= wlo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed and random operations checked against
// a 64-bit arithmetic reference, with a behavioural ALU and a randomly denying grant.
module tb_alu_muldiv_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_fun;
    logic        alu_sign;
    logic [31:0] alu_z;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] last_res = 64'd0;

    alu_muldiv_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .alu_req (alu_req),
        .alu_gnt (alu_gnt),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_fun (alu_fun),
        .alu_sign(alu_sign),
        .alu_z   (alu_z)
    );

    always #5 clk = ~clk;

    // Shared ALU: combinational add/sub
    always_comb begin
        alu_z = (alu_fun == 6'b000001) ? (alu_a - alu_b) : (alu_a + alu_b);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference result {hi,lo} from plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: p = {32'd0, a} * {32'd0, b};
            2'b01: p = 64'(sa * sb);
            2'b10: p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    // Launch one operation at a negedge, run it to done and check everything observable
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int ndeny, input bit poke);
        logic [63:0] exp_res;
        logic [31:0] dmask;
        int          lat, exp_lat, k, nbusy, nreq, bad_alu, hold_bad;
        bit          dz;
        exp_res = model(o, a, b);
        dz      = o[1] && (b == 32'd0);
        dmask   = 32'd0;
        while ($countones(dmask) < ndeny) dmask[$urandom_range(0, 31)] = 1'b1;
        exp_lat = dz ? 3 : 35 + ndeny;
        op = o; rs_val = a; rt_val = b; start = 1'b1; alu_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1; k = 0; nbusy = 0; nreq = 0; bad_alu = 0; hold_bad = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) nbusy++;
            if ({hi, lo} !== last_res) hold_bad++;
            if (alu_req === 1'b1) begin
                nreq++;
                if (alu_fun !== {5'd0, o[1]} || alu_sign !== 1'b0) bad_alu++;
                alu_gnt = (k < 32) ? ~dmask[k] : 1'b1;
                k++;
            end else begin
                if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_fun !== 6'd0 || alu_sign !== 1'b0) bad_alu++;
                alu_gnt = 1'b1;
            end
            if (poke && lat == 5) begin
                start = 1'b1; op = ~o; rs_val = $urandom; rt_val = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        alu_gnt = 1'b1;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_hi"}, 64'(hi), 64'(exp_res[63:32]));
        check({tag, "_lo"}, 64'(lo), 64'(exp_res[31:0]));
        check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        check({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat - 1));
        check({tag, "_req_cycles"}, 64'(nreq), dz ? 64'd0 : 64'(32 + ndeny));
        check({tag, "_alu_drive"}, 64'(bad_alu), 64'd0);
        check({tag, "_hilo_hold"}, 64'(hold_bad), 64'd0);
        last_res = exp_res;
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = 32'd0; rt_val = 32'd0; alu_gnt = 1'b1;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_req", 64'(alu_req), 64'd0);
        check("rst_alu", {26'd0, alu_fun, alu_sign, alu_a | alu_b}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        check("multu_max_lit", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
        check("mult_neg_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        check("div_neg_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 0, 1'b0);
        check("divu_100_7_lit", {hi, lo}, {32'd2, 32'd14});

        // Abort mid-ITER with count at 10
        op = 2'b00; rs_val = 32'd5; rt_val = 32'd9; start = 1'b1; alu_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("abort_pre_req", 64'(alu_req), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_req", 64'(alu_req), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        last_res = 64'd0;
        @(negedge clk);
        run_op("multu_2x3", 2'b00, 32'd2, 32'd3, 0, 1'b0);
        check("multu_2x3_lit", 64'(lo), 64'd6);

        run_op("divu_zero", 2'b10, 32'h1234_5678, 32'd0, 0, 1'b0);
        check("divu_zero_lit", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        check("div_ovf_lit", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op("multu_deny", 2'b00, 32'd6, 32'd7, 5, 1'b1);
        check("multu_deny_lit", {hi, lo}, 64'd42);
        run_op("div_neg_zero", 2'b11, 32'hFFFF_FF00, 32'd0, 0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run_op($sformatf("rand%0d", i), rop, ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
